// File: rtl/axis_packet_generator.sv
// axis_packet_generator: AXI-Lite programmed AXI4-Stream packet source.
// Emits PKT_CNT packets of PKT_LEN beats after START_DELAY, GAP apart.
//
// Ports:
//   s0_axi_aclk / s0_axi_areset : clock, synchronous active-high reset
//   s0_axi_aw* / w* / b*        : AXI-Lite write (5-bit addr, 8 word regs)
//   s0_axi_ar* / r*             : AXI-Lite read
//   m0_axis_t*                  : AXI4-Stream master, tdata = beat counter
//
// Register map (word index = addr[4:2]):
//   0 CTRL (bit0 START pulse)  1 START_DELAY  2 GAP  3 PKT_LEN
//   4 PKT_CNT  5 STATUS (bit0 DONE, bit1 BUSY, RO)  6-7 reserved

module axis_packet_generator #(
  parameter int C_S0_AXI_DATA_WIDTH   = 32,
  parameter int C_S0_AXI_ADDR_WIDTH   = 5,
  parameter int C_M0_AXIS_TDATA_WIDTH = 32
) (
  input  logic                               s0_axi_aclk,
  input  logic                               s0_axi_areset,
  input  logic [C_S0_AXI_ADDR_WIDTH-1:0]     s0_axi_awaddr,
  input  logic [2:0]                         s0_axi_awprot,
  input  logic                               s0_axi_awvalid,
  output logic                               s0_axi_awready,
  input  logic [C_S0_AXI_DATA_WIDTH-1:0]     s0_axi_wdata,
  input  logic [C_S0_AXI_DATA_WIDTH/8-1:0]   s0_axi_wstrb,
  input  logic                               s0_axi_wvalid,
  output logic                               s0_axi_wready,
  output logic [1:0]                         s0_axi_bresp,
  output logic                               s0_axi_bvalid,
  input  logic                               s0_axi_bready,
  input  logic [C_S0_AXI_ADDR_WIDTH-1:0]     s0_axi_araddr,
  input  logic [2:0]                         s0_axi_arprot,
  input  logic                               s0_axi_arvalid,
  output logic                               s0_axi_arready,
  output logic [C_S0_AXI_DATA_WIDTH-1:0]     s0_axi_rdata,
  output logic [1:0]                         s0_axi_rresp,
  output logic                               s0_axi_rvalid,
  input  logic                               s0_axi_rready,
  output logic                               m0_axis_tvalid,
  output logic [C_M0_AXIS_TDATA_WIDTH-1:0]   m0_axis_tdata,
  output logic                               m0_axis_tlast,
  input  logic                               m0_axis_tready
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DELAY,
    S_SEND,
    S_GAP
  } state_t;

  state_t state;
  state_t state_next;

  logic        clk;
  logic        rst;
  assign clk = s0_axi_aclk;
  assign rst = s0_axi_areset;

  // write-side handshake and decode
  logic        wr_rdy;
  logic        aw_hs;
  logic        ar_hs;
  logic [2:0]  wr_idx;
  logic [2:0]  rd_idx;
  logic        start_req;

  // software-visible configuration
  logic [31:0] reg_delay;
  logic [31:0] reg_gap;
  logic [31:0] reg_len;
  logic [31:0] reg_cnt;
  logic [31:0] rd_val;

  // run-time working copies
  logic [31:0] len_w;
  logic [31:0] gap_w;
  logic [31:0] pkts_left;
  logic [31:0] beat_idx;
  logic [31:0] wait_cnt;
  logic [31:0] beat_cnt;
  logic        done;
  logic        busy;

  // FSM control strobes
  logic        load;
  logic        wait_dec;
  logic        gap_load;
  logic        beat_acc;
  logic        pkt_end;
  logic        finish;
  logic        is_last;

  assign s0_axi_awready = wr_rdy;
  assign s0_axi_wready  = wr_rdy;
  assign s0_axi_bresp   = 2'b00;
  assign s0_axi_rresp   = 2'b00;

  // wr_rdy only rises while both valids are up, so aw_hs implies w too
  assign aw_hs  = wr_rdy && s0_axi_awvalid && s0_axi_wvalid;
  assign ar_hs  = s0_axi_arready && s0_axi_arvalid;
  assign wr_idx = s0_axi_awaddr[4:2];
  assign rd_idx = s0_axi_araddr[4:2];

  assign start_req = aw_hs && (wr_idx == 3'd0)
                  && s0_axi_wstrb[0] && s0_axi_wdata[0];

  assign busy    = (state != S_IDLE);
  assign is_last = (beat_idx == len_w - 32'd1);

  assign m0_axis_tvalid = (state == S_SEND);
  assign m0_axis_tlast  = (state == S_SEND) && is_last;
  assign m0_axis_tdata  = C_M0_AXIS_TDATA_WIDTH'(beat_cnt);

  logic unused_ok;
  assign unused_ok = ^{s0_axi_awprot, s0_axi_arprot,
                       s0_axi_awaddr[1:0], s0_axi_araddr[1:0]};

  function automatic logic [31:0] apply_strb(
    input logic [31:0] old,
    input logic [31:0] d,
    input logic [3:0]  s
  );
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) begin
      if (s[i]) r[i*8 +: 8] = d[i*8 +: 8];
    end
    return r;
  endfunction

  always_comb begin
    rd_val = 32'd0;
    unique case (rd_idx)
      3'd1:    rd_val = reg_delay;
      3'd2:    rd_val = reg_gap;
      3'd3:    rd_val = reg_len;
      3'd4:    rd_val = reg_cnt;
      3'd5:    rd_val = {30'd0, busy, done};
      default: rd_val = 32'd0;
    endcase
  end

  // AXI-Lite slave and configuration registers
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_rdy         <= 1'b0;
      s0_axi_bvalid  <= 1'b0;
      s0_axi_arready <= 1'b0;
      s0_axi_rvalid  <= 1'b0;
      s0_axi_rdata   <= '0;
      reg_delay      <= 32'd0;
      reg_gap        <= 32'd0;
      reg_len        <= 32'd0;
      reg_cnt        <= 32'd0;
    end else begin
      // !wr_rdy keeps the ready a single-cycle pulse
      wr_rdy <= s0_axi_awvalid && s0_axi_wvalid
             && !s0_axi_bvalid && !wr_rdy;
      if (aw_hs) begin
        s0_axi_bvalid <= 1'b1;
      end else if (s0_axi_bready) begin
        s0_axi_bvalid <= 1'b0;
      end
      if (aw_hs) begin
        unique case (wr_idx)
          3'd1: reg_delay <= apply_strb(reg_delay, s0_axi_wdata,
                                        s0_axi_wstrb);
          3'd2: reg_gap   <= apply_strb(reg_gap, s0_axi_wdata,
                                        s0_axi_wstrb);
          3'd3: reg_len   <= apply_strb(reg_len, s0_axi_wdata,
                                        s0_axi_wstrb);
          3'd4: reg_cnt   <= apply_strb(reg_cnt, s0_axi_wdata,
                                        s0_axi_wstrb);
          default: ;
        endcase
      end
      s0_axi_arready <= s0_axi_arvalid && !s0_axi_rvalid
                     && !s0_axi_arready;
      if (ar_hs) begin
        s0_axi_rvalid <= 1'b1;
        s0_axi_rdata  <= rd_val;
      end else if (s0_axi_rready) begin
        s0_axi_rvalid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    load       = 1'b0;
    wait_dec   = 1'b0;
    gap_load   = 1'b0;
    beat_acc   = 1'b0;
    pkt_end    = 1'b0;
    finish     = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (start_req) begin
          state_next = S_DELAY;
          load       = 1'b1;
        end
      end
      S_DELAY: begin
        // wait_cnt==0 costs one cycle, giving START_DELAY+1 total
        if (wait_cnt == 32'd0) begin
          if (len_w == 32'd0 || pkts_left == 32'd0) begin
            state_next = S_IDLE;
            finish     = 1'b1;
          end else begin
            state_next = S_SEND;
          end
        end else begin
          wait_dec = 1'b1;
        end
      end
      S_SEND: begin
        if (m0_axis_tready) begin
          beat_acc = 1'b1;
          if (is_last) begin
            pkt_end = 1'b1;
            if (pkts_left == 32'd1) begin
              state_next = S_IDLE;
              finish     = 1'b1;
            end else if (gap_w != 32'd0) begin
              state_next = S_GAP;
              gap_load   = 1'b1;
            end
          end
        end
      end
      S_GAP: begin
        if (wait_cnt == 32'd0) begin
          state_next = S_SEND;
        end else begin
          wait_dec = 1'b1;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      len_w     <= 32'd0;
      gap_w     <= 32'd0;
      pkts_left <= 32'd0;
      beat_idx  <= 32'd0;
      wait_cnt  <= 32'd0;
      beat_cnt  <= 32'd0;
      done      <= 1'b0;
    end else begin
      if (load) begin
        len_w     <= reg_len;
        gap_w     <= reg_gap;
        pkts_left <= reg_cnt;
        wait_cnt  <= reg_delay;
        beat_idx  <= 32'd0;
        beat_cnt  <= 32'd0;
        done      <= 1'b0;
      end
      if (wait_dec) begin
        wait_cnt <= wait_cnt - 32'd1;
      end
      // GAP state lasts gap_w cycles: load gap_w-1, leave at zero
      if (gap_load) begin
        wait_cnt <= gap_w - 32'd1;
      end
      if (beat_acc) begin
        beat_cnt <= beat_cnt + 32'd1;
        beat_idx <= pkt_end ? 32'd0 : beat_idx + 32'd1;
      end
      if (pkt_end) begin
        pkts_left <= pkts_left - 32'd1;
      end
      if (finish) begin
        done <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_axis_packet_generator.sv
// tb_axis_packet_generator: scoreboard bench for axis_packet_generator.
// Random backpressure; expected beats come from a per-run model queue.

module tb_axis_packet_generator;

  logic        clk = 1'b0;
  logic        areset = 1'b1;
  logic [4:0]  awaddr = '0;
  logic        awvalid = 1'b0;
  logic        awready;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        wvalid = 1'b0;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready = 1'b0;
  logic [4:0]  araddr = '0;
  logic        arvalid = 1'b0;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready = 1'b0;
  logic        tvalid;
  logic [31:0] tdata;
  logic        tlast;
  logic        tready = 1'b0;

  axis_packet_generator dut (
    .s0_axi_aclk    (clk),
    .s0_axi_areset  (areset),
    .s0_axi_awaddr  (awaddr),
    .s0_axi_awprot  (3'b000),
    .s0_axi_awvalid (awvalid),
    .s0_axi_awready (awready),
    .s0_axi_wdata   (wdata),
    .s0_axi_wstrb   (wstrb),
    .s0_axi_wvalid  (wvalid),
    .s0_axi_wready  (wready),
    .s0_axi_bresp   (bresp),
    .s0_axi_bvalid  (bvalid),
    .s0_axi_bready  (bready),
    .s0_axi_araddr  (araddr),
    .s0_axi_arprot  (3'b000),
    .s0_axi_arvalid (arvalid),
    .s0_axi_arready (arready),
    .s0_axi_rdata   (rdata),
    .s0_axi_rresp   (rresp),
    .s0_axi_rvalid  (rvalid),
    .s0_axi_rready  (rready),
    .m0_axis_tvalid (tvalid),
    .m0_axis_tdata  (tdata),
    .m0_axis_tlast  (tlast),
    .m0_axis_tready (tready)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] data;
    logic        last;
    int          gap_before;
  } beat_t;

  beat_t exp_q[$];
  int errors = 0;
  int checks = 0;
  int tr_mode = 1;
  int accepted = 0;
  int idle = 0;
  int run_len = 0;
  int last_run = 0;
  int hs_cyc = 0;
  int exp_delay = 0;
  bit delay_pending = 1'b0;
  bit capture_hs = 1'b0;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // model: beats numbered across the run, tlast on each packet end,
  // required idle cycles recorded on the first beat of later packets
  task automatic push_run(input int d, input int g, input int l,
                          input int c);
    int k;
    beat_t b;
    k = 0;
    capture_hs = 1'b1;
    if (l > 0 && c > 0) begin
      exp_delay = d;
      delay_pending = 1'b1;
      for (int p = 0; p < c; p++) begin
        for (int i = 0; i < l; i++) begin
          b.data = k;
          b.last = (i == l - 1);
          b.gap_before = (i != 0) ? 0 : ((p == 0) ? -1 : g);
          exp_q.push_back(b);
          k++;
        end
      end
    end
  endtask

  // tready driver
  initial forever begin
    @(posedge clk);
    #1;
    case (tr_mode)
      0:       tready = 1'($urandom_range(0, 1));
      1:       tready = 1'b1;
      default: tready = 1'b0;
    endcase
  end

  // stream monitor
  initial begin
    beat_t b;
    logic prev_stall;
    logic [31:0] prev_data;
    logic prev_last;
    prev_stall = 1'b0;
    prev_data = '0;
    prev_last = 1'b0;
    forever begin
      @(negedge clk);
      if (areset) begin
        idle = 0;
        run_len = 0;
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          chk("hold_tvalid", tvalid, 1);
          chk("hold_tdata", tdata, prev_data);
          chk("hold_tlast", tlast, prev_last);
        end
        if (tvalid) begin
          run_len++;
          if (delay_pending) begin
            chk("start_delay", cyc - hs_cyc, exp_delay + 1);
            delay_pending = 1'b0;
          end
          if (tready) begin
            if (exp_q.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL unexpected_beat: tdata=0x%0h", tdata);
            end else begin
              b = exp_q.pop_front();
              chk("tdata", tdata, b.data);
              chk("tlast", tlast, b.last);
              if (b.gap_before >= 0)
                chk("idle_cycles", idle, b.gap_before);
              accepted++;
            end
            idle = 0;
          end
        end else begin
          idle++;
          if (run_len > 0) last_run = run_len;
          run_len = 0;
        end
        prev_stall = tvalid && !tready;
        prev_data = tdata;
        prev_last = tlast;
      end
    end
  end

  task automatic axi_write(input logic [4:0] a, input logic [31:0] d,
                           input logic [3:0] s);
    int n;
    @(posedge clk);
    #1;
    awaddr = a;
    wdata = d;
    wstrb = s;
    awvalid = 1'b1;
    wvalid = 1'b1;
    n = 0;
    while (!awready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!awready) begin
      checks++;
      errors++;
      $display("FAIL aw_timeout: addr=0x%0h", a);
      awvalid = 1'b0;
      wvalid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    if (capture_hs) begin
      hs_cyc = cyc;
      capture_hs = 1'b0;
    end
    awvalid = 1'b0;
    wvalid = 1'b0;
    bready = 1'b1;
    n = 0;
    while (!bvalid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("bvalid", bvalid, 1);
    chk("bresp", bresp, 0);
    @(posedge clk);
    #1;
    bready = 1'b0;
  endtask

  task automatic axi_read(input logic [4:0] a, output logic [31:0] d);
    int n;
    d = '0;
    @(posedge clk);
    #1;
    araddr = a;
    arvalid = 1'b1;
    n = 0;
    while (!arready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!arready) begin
      checks++;
      errors++;
      $display("FAIL ar_timeout: addr=0x%0h", a);
      arvalid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    arvalid = 1'b0;
    rready = 1'b1;
    n = 0;
    while (!rvalid && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    if (!rvalid) begin
      checks++;
      errors++;
      $display("FAIL r_timeout: addr=0x%0h", a);
    end
    d = rdata;
    if (rresp !== 2'b00) begin
      checks++;
      errors++;
      $display("FAIL rresp: got %0d expected 0", rresp);
    end
    @(posedge clk);
    #1;
    rready = 1'b0;
  endtask

  task automatic read_chk(input string name, input logic [4:0] a,
                          input logic [31:0] e);
    logic [31:0] d;
    axi_read(a, d);
    chk(name, d, e);
  endtask

  task automatic poll_status(input string name, input logic [31:0] e);
    logic [31:0] d;
    d = '0;
    for (int i = 0; i < 1000; i++) begin
      axi_read(5'h14, d);
      if (d == e) break;
    end
    chk(name, d, e);
  endtask

  task automatic config_run(input int d, input int g, input int l,
                            input int c);
    axi_write(5'h04, d, 4'hf);
    axi_write(5'h08, g, 4'hf);
    axi_write(5'h0c, l, 4'hf);
    axi_write(5'h10, c, 4'hf);
  endtask

  task automatic wait_beats(input int target);
    int n;
    n = 0;
    while (accepted < target && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("wait_beats", accepted >= target, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;

    // reset
    areset = 1'b1;
    repeat (50) @(posedge clk);
    @(negedge clk);
    chk("rst_ctrl_outs",
        {awready, wready, bvalid, arready, rvalid, tvalid, tlast}, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_tdata", tdata, 0);
    chk("rst_resp", {bresp, rresp}, 0);
    @(posedge clk);
    #1;
    areset = 1'b0;
    read_chk("rst_status", 5'h14, 32'h0);

    // register access
    for (int r = 1; r <= 4; r++)
      axi_write(5'(r * 4), 32'h12345678, 4'hf);
    for (int r = 1; r <= 4; r++)
      read_chk("reg_rw", 5'(r * 4), 32'h12345678);
    axi_write(5'h18, 32'hffffffff, 4'hf);
    read_chk("reg6_zero", 5'h18, 32'h0);
    read_chk("ctrl_zero", 5'h00, 32'h0);
    axi_write(5'h14, 32'h3, 4'hf);
    read_chk("status_ro", 5'h14, 32'h0);
    axi_write(5'h08, 32'haabbccdd, 4'b0001);
    read_chk("wstrb_byte0", 5'h08, 32'h123456dd);

    // basic run with random tready
    tr_mode = 0;
    base = accepted;
    config_run(0, 100, 9, 4);
    push_run(0, 100, 9, 4);
    axi_write(5'h00, 32'h1, 4'hf);
    poll_status("basic_done", 32'h1);
    chk("basic_beats", accepted - base, 36);
    chk("basic_q_empty", exp_q.size(), 0);

    // backpressure mid-packet
    tr_mode = 1;
    base = accepted;
    config_run(2, 3, 9, 2);
    push_run(2, 3, 9, 2);
    axi_write(5'h00, 32'h1, 4'hf);
    wait_beats(base + 4);
    tr_mode = 2;
    repeat (20) @(posedge clk);
    @(negedge clk);
    chk("bp_stalled_valid", tvalid, 1);
    tr_mode = 0;
    poll_status("bp_done", 32'h1);
    chk("bp_beats", accepted - base, 18);
    chk("bp_q_empty", exp_q.size(), 0);

    // delay / zero-gap precision
    tr_mode = 1;
    base = accepted;
    config_run(10, 0, 3, 2);
    push_run(10, 0, 3, 2);
    axi_write(5'h00, 32'h1, 4'hf);
    poll_status("prec_done", 32'h1);
    chk("prec_run_len", last_run, 6);
    chk("prec_beats", accepted - base, 6);

    // PKT_CNT=0: DONE clears on START, then sets with no beats
    base = accepted;
    config_run(30, 0, 3, 0);
    push_run(30, 0, 3, 0);
    axi_write(5'h00, 32'h1, 4'hf);
    read_chk("cnt0_busy", 5'h14, 32'h2);
    poll_status("cnt0_done", 32'h1);
    chk("cnt0_beats", accepted - base, 0);

    // START while busy is ignored, config latched at START
    base = accepted;
    config_run(5, 5, 4, 3);
    push_run(5, 5, 4, 3);
    axi_write(5'h00, 32'h1, 4'hf);
    read_chk("busy_status", 5'h14, 32'h2);
    axi_write(5'h0c, 32'd7, 4'hf);
    axi_write(5'h00, 32'h1, 4'hf);
    poll_status("busy_done", 32'h1);
    chk("busy_beats", accepted - base, 12);
    chk("busy_q_empty", exp_q.size(), 0);
    read_chk("busy_len_reg", 5'h0c, 32'd7);

    // reset mid-packet
    base = accepted;
    config_run(0, 0, 20, 3);
    push_run(0, 0, 20, 3);
    axi_write(5'h00, 32'h1, 4'hf);
    wait_beats(base + 5);
    @(posedge clk);
    #1;
    areset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("abort_tvalid", tvalid, 0);
    chk("abort_tdata", tdata, 0);
    @(posedge clk);
    #1;
    areset = 1'b0;
    exp_q.delete();
    delay_pending = 1'b0;
    read_chk("abort_status", 5'h14, 32'h0);
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("abort_idle", tvalid, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
